pwm_multi_channel: RTL and testbench
====================================

// Module: pwm_multi_channel
// PURPOSE
//  Parametrised N-channel PWM generator; successor to the fixed 16-output pwm_peripheral.
//  Shared prescaler and period counter; per-channel duty with shadow registers.
//  Duty/period/prescale changes are applied only at period wrap, giving glitch-free updates.
//  Sits behind the SPI/config register file; out[] drives the uo_out/uio_out pads.
// PARAMETERS
//  NUM_CH   16  number of output channels
//  CNT_W     8  width of the period counter, duty and top
//  PRESC_W   4  width of the prescale divisor
// PORTS
//  clk         in   1                  system clock; the only clock
//  rst_n       in   1                  reset, synchronous, active-low
//  en_out      in   NUM_CH             per-channel output enable
//  en_pwm      in   NUM_CH             1 = PWM waveform; 0 = static high (when en_out=1)
//  wr_en       in   1                  one-cycle duty write strobe
//  wr_ch       in   $clog2(NUM_CH)     channel index for the write
//  wr_duty     in   CNT_W              duty value for the write
//  top_in      in   CNT_W              requested period top (period = top+1 ticks)
//  presc_in    in   PRESC_W            requested prescale (tick every presc+1 clocks)
//  out         out  NUM_CH             registered PWM outputs
//  period_start out 1                  one-cycle pulse on the first cycle of each period
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): out=0, period_start=0, presc_cnt=0, cnt=0,
//   pending/shadow duty=0, top_sh={CNT_W{1}}, presc_sh=0. Reset overrides all other inputs.
//  Prescaler:
//   - presc_cnt counts 0..presc_sh.
//   - tick=1 when presc_cnt==presc_sh, then presc_cnt->0; presc_sh=0 gives tick every clock.
//  Period counter:
//   - cnt advances on tick.
//   - wrap = tick && cnt==top_sh: cnt->0, else cnt+1. No other wrap exists.
//  Shadow load on the wrap cycle: duty_sh[i]<=pending[i], top_sh<=top_in, presc_sh<=presc_in.
//   - Also performed on the first clock after reset release.
//  Writes:
//   - wr_en with wr_ch<NUM_CH sets pending[wr_ch]<=wr_duty.
//   - wr_ch>=NUM_CH: write ignored.
//   - Write in the wrap cycle is bypassed into that same load (new value used next period).
//   - Repeated writes within a period: last write wins.
//  Compare:
//   - pwm_i = (cnt < duty_sh[i]), unsigned CNT_W compare.
//   - duty=0: constant low.
//   - duty>top_sh: constant high.
//   - High time = min(duty, top+1) ticks per period.
//  Output register: out[i] <= en_out[i] & (en_pwm[i] ? pwm_i : 1).
//   - 1 clock latency from cnt/en change to out.
//   - en_out=0 forces out[i]=0 regardless of en_pwm.
//  period_start: registered; high for exactly one clock after each wrap (when cnt==0 first seen).
//  top_in/presc_in changes mid-period have no effect until the next wrap.
//  Reset mid-period: all state returns to reset values next clock; pending writes lost.
// TESTING
//  1. Hold rst_n=0 5 clks, en_out=all1, en_pwm=0 -> out=0; 1 clk after release -> out=all1.
//  2. top=255, presc=0, ch0 duty=128, en ch0 pwm -> out[0] high 128 / low 128 clks,
//     period_start every 256 clks.
//  3. ch1 duty=0 -> always 0; ch2 duty=255 -> high 255/256; top=99, ch3 duty=100 -> always 1.
//  4. Write ch0 duty 64 mid-period (cnt=30) -> current period keeps 128; next period 64.
//     Write in the wrap cycle takes effect in the following period.
//  5. presc=3, top=9, duty=5 -> 40-clk period, 20 clks high; presc change mid-period applies
//     only after wrap.
//  6. wr_ch=NUM_CH -> no pending change.
//     Reset asserted at cnt=50 -> out=0, cnt=0 next clk, duties 0 after release.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator with a shared prescaler and period counter.
// Per-channel duty, period top and prescale are double-buffered and take effect only at period wrap.
module pwm_multi_channel #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         en_out,
  input  logic [NUM_CH-1:0]         en_pwm,
  input  logic                      wr_en,
  input  logic [$clog2(NUM_CH)-1:0] wr_ch,
  input  logic [CNT_W-1:0]          wr_duty,
  input  logic [CNT_W-1:0]          top_in,
  input  logic [PRESC_W-1:0]        presc_in,
  output logic [NUM_CH-1:0]         out,
  output logic                      period_start
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [PRESC_W-1:0] presc_cnt;
  logic [PRESC_W-1:0] presc_sh;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   top_sh;
  logic [CNT_W-1:0]   pending     [NUM_CH];
  logic [CNT_W-1:0]   pending_nxt [NUM_CH];
  logic [CNT_W-1:0]   duty_sh     [NUM_CH];
  logic               first_p0;
  logic               tick;
  logic               wrap;
  logic               load;
  logic               wr_ok;
  logic [NUM_CH-1:0]  pwm;
  logic [NUM_CH-1:0]  out_nxt;

  // When NUM_CH fills the index range every index is legal; otherwise reject the excess.
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_full_idx
      assign wr_ok = 1'b1;
    end else begin : g_part_idx
      assign wr_ok = (wr_ch < CH_W'(NUM_CH));
    end
  endgenerate

  always_comb begin
    tick = (presc_cnt == presc_sh);
    wrap = tick && (cnt == top_sh);
    load = wrap || first_p0;
    for (int i = 0; i < NUM_CH; i++) begin
      pending_nxt[i] = pending[i];
      if (wr_en && wr_ok && (wr_ch == CH_W'(i))) begin
        pending_nxt[i] = wr_duty;
      end
      pwm[i]     = (cnt < duty_sh[i]);
      out_nxt[i] = en_out[i] & (en_pwm[i] ? pwm[i] : 1'b1);
    end
  end

  // Stage p0 -> registered state and outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_cnt    <= '0;
      presc_sh     <= '0;
      cnt          <= '0;
      top_sh       <= '1;
      first_p0     <= 1'b1;
      out          <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        pending[i] <= '0;
        duty_sh[i] <= '0;
      end
    end else begin
      first_p0     <= 1'b0;
      out          <= out_nxt;
      period_start <= wrap;
      if (tick) begin
        presc_cnt <= '0;
        cnt       <= wrap ? '0 : cnt + 1'b1;
      end else begin
        presc_cnt <= presc_cnt + 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        pending[i] <= pending_nxt[i];
      end
      // The load sees pending_nxt so a write in the wrap cycle lands in the new period.
      if (load) begin
        top_sh   <= top_in;
        presc_sh <= presc_in;
        for (int i = 0; i < NUM_CH; i++) begin
          duty_sh[i] <= pending_nxt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel: a reference model queues the expected outputs per edge,
// plus per-period high-time and period_start counts checked against values derived by hand.
module tb_pwm_multi_channel;

  localparam int NUM_CH  = 12;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 4;
  localparam int CH_W    = $clog2(NUM_CH);

  logic                clk;
  logic                rst_n;
  logic [NUM_CH-1:0]   en_out;
  logic [NUM_CH-1:0]   en_pwm;
  logic                wr_en;
  logic [CH_W-1:0]     wr_ch;
  logic [CNT_W-1:0]    wr_duty;
  logic [CNT_W-1:0]    top_in;
  logic [PRESC_W-1:0]  presc_in;
  logic [NUM_CH-1:0]   out;
  logic                period_start;

  pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst_n(rst_n), .en_out(en_out), .en_pwm(en_pwm),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
    .top_in(top_in), .presc_in(presc_in),
    .out(out), .period_start(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] o;
    logic              ps;
  } exp_t;

  exp_t sb[$];

  logic [PRESC_W-1:0] m_pc, m_psh;
  logic [CNT_W-1:0]   m_cnt, m_top;
  logic [CNT_W-1:0]   m_pend [NUM_CH];
  logic [CNT_W-1:0]   m_duty [NUM_CH];
  bit                 m_first;

  int n_checks = 0;
  int n_fail   = 0;
  int hi [NUM_CH];
  int ps_seen;
  logic last_ps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for the coming clock edge, using the inputs now driven.
  task automatic model_edge(output exp_t e);
    bit tick, wrap;
    e = '0;
    if (!rst_n) begin
      m_pc = '0; m_psh = '0; m_cnt = '0; m_top = '1; m_first = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        m_pend[i] = '0;
        m_duty[i] = '0;
      end
    end else begin
      tick = (m_pc == m_psh);
      wrap = tick && (m_cnt == m_top);
      if (wr_en && (int'(wr_ch) < NUM_CH)) m_pend[wr_ch] = wr_duty;
      for (int i = 0; i < NUM_CH; i++)
        e.o[i] = en_out[i] && (en_pwm[i] ? (m_cnt < m_duty[i]) : 1'b1);
      e.ps = wrap;
      if (tick) begin
        m_pc  = '0;
        m_cnt = wrap ? '0 : m_cnt + 1'b1;
      end else begin
        m_pc = m_pc + 1'b1;
      end
      if (wrap || m_first) begin
        m_top = top_in;
        m_psh = presc_in;
        for (int i = 0; i < NUM_CH; i++) m_duty[i] = m_pend[i];
      end
      m_first = 1'b0;
    end
  endtask

  task automatic step();
    exp_t e;
    model_edge(e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("out", 32'(out), 32'(e.o));
    check("period_start", 32'(period_start), 32'(e.ps));
    for (int i = 0; i < NUM_CH; i++) hi[i] += int'(out[i]);
    ps_seen += int'(period_start);
    last_ps = period_start;
  endtask

  task automatic clr();
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    ps_seen = 0;
  endtask

  task automatic wr(input int ch, input int d);
    wr_ch   = CH_W'(ch);
    wr_duty = CNT_W'(d);
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_wrap();
    int k = 0;
    do begin
      step();
      k++;
    end while (!last_ps && k < 2000);
    check("wrap_timeout", 32'(last_ps), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; en_out = '1; en_pwm = '0; wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
    top_in = 8'd255; presc_in = 4'd0; last_ps = 1'b0;
    clr();
    #1;

    // Reset hold, then release with static-high channels.
    repeat (5) step();
    check("rst_out", 32'(out), 32'd0);
    rst_n = 1'b1;
    step();
    check("rel_out", 32'(out), 32'hFFF);

    // Basic duties, top 255: ch4-7 static high, ch8-11 disabled.
    en_pwm = 12'h00F;
    en_out = 12'h0FF;
    wr(0, 128); wr(1, 0); wr(2, 255); wr(3, 100);
    wait_wrap();
    clr();
    repeat (256) step();
    check("hi0_128", hi[0], 128);
    check("hi1_zero", hi[1], 0);
    check("hi2_255", hi[2], 255);
    check("hi3_100", hi[3], 100);
    check("hi4_static", hi[4], 256);
    check("hi8_off", hi[8], 0);
    check("ps_per256", ps_seen, 1);

    // Top 99: duty above top stays high all period.
    top_in = 8'd99;
    wait_wrap();
    clr();
    repeat (100) step();
    check("t99_hi3", hi[3], 100);
    check("t99_hi0", hi[0], 100);
    check("t99_hi1", hi[1], 0);
    check("t99_ps", ps_seen, 1);

    // Mid-period write and wrap-cycle write.
    top_in = 8'd255;
    wait_wrap();
    clr();
    repeat (30) step();
    wr(0, 64);
    repeat (225) step();
    check("mid_keep128", hi[0], 128);
    clr();
    repeat (255) step();
    wr(0, 200);
    check("next_64", hi[0], 64);
    check("wrapwr_ps", ps_seen, 1);
    clr();
    repeat (256) step();
    check("wrapwr_200", hi[0], 200);

    // en_out low forces the PWM channel off.
    en_out = 12'h0FE;
    clr();
    repeat (256) step();
    check("enout_off", hi[0], 0);
    en_out = 12'h0FF;

    // Prescale 3, top 9, duty 5; prescale change mid-period.
    presc_in = 4'd3;
    top_in   = 8'd9;
    wr(0, 5);
    wait_wrap();
    clr();
    repeat (40) step();
    check("p3_hi0", hi[0], 20);
    check("p3_ps", ps_seen, 1);
    clr();
    repeat (10) step();
    presc_in = 4'd1;
    repeat (30) step();
    check("p3_hold_hi0", hi[0], 20);
    check("p3_hold_ps", ps_seen, 1);
    clr();
    repeat (20) step();
    check("p1_hi0", hi[0], 10);
    check("p1_ps", ps_seen, 1);

    // Out-of-range write index is ignored.
    presc_in = 4'd0;
    top_in   = 8'd255;
    wait_wrap();
    clr();
    wr(12, 77);
    repeat (255) step();
    check("badch_cur", hi[0], 5);
    clr();
    repeat (256) step();
    check("badch_next", hi[0], 5);

    // Reset mid-period at cnt=50.
    repeat (50) step();
    rst_n = 1'b0;
    step();
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_ps", 32'(period_start), 32'd0);
    rst_n = 1'b1;
    step();
    check("postrst_out", 32'(out), 32'h0F0);
    clr();
    repeat (256) step();
    check("postrst_hi0", hi[0], 0);
    check("postrst_hi2", hi[2], 0);
    check("postrst_ps", ps_seen, 1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
